// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an 8-entry FIFO read port and shifts each
// out as an asynchronous frame (start, 8 data bits LSB first, stop).
// Optional feature macro: FIFO_UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit (11-bit frame).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_enb,
  output logic       tx,
  output logic       busy,
  output logic [7:0] byte_cnt
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PAR   = 3'd5,
`endif
    STOP  = 3'd6
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic              baud_last;
  logic              can_start;

`ifdef FIFO_UART_TX_PARITY_EN
  logic              par_q;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign can_start = enable && !fifo_empty;

  // State register; reset drops any frame in flight and parks the line high.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_nxt   = state;
    tx          = 1'b1;
    fifo_rd_enb = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:  if (can_start) state_nxt = POP;
      POP: begin
        fifo_rd_enb = 1'b1;
        state_nxt   = LOAD;
      end
      LOAD:  state_nxt = START;
      START: begin
        tx = 1'b0;
        if (baud_last) state_nxt = DATA;
      end
      DATA: begin
        tx = shift_q[0];
        if (baud_last && bit_cnt == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PAR: begin
        tx = par_q;
        if (baud_last) state_nxt = STOP;
      end
`endif
      STOP: begin
        tx = 1'b1;
        if (baud_last) state_nxt = can_start ? POP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Baud and bit counters: cleared at LOAD, baud wraps every bit period,
  // bit counter advances once per data bit.
  always_ff @(posedge clk) begin
    if (rst || state == LOAD) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
    end else if (state == START || state == DATA || state == STOP
`ifdef FIFO_UART_TX_PARITY_EN
                 || state == PAR
`endif
                 ) begin
      baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);
      if (state == DATA && baud_last) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Completed-frame counter, bumped on the final stop-bit cycle.
  always_ff @(posedge clk) begin
    if (rst)                          byte_cnt <= 8'd0;
    else if (state == STOP && baud_last) byte_cnt <= byte_cnt + 8'd1;
  end

  // Data shift register: loaded from the FIFO read data, shifted per bit.
  always_ff @(posedge clk) begin
    if (state == LOAD)                   shift_q <= fifo_data;
    else if (state == DATA && baud_last) shift_q <= {1'b0, shift_q[7:1]};
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Parity is taken from the whole byte at load, before shifting destroys it.
  always_ff @(posedge clk) begin
    if (state == LOAD) par_q <= even_parity(fifo_data);
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a
// small registered-read FIFO model on the read port.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [NB-1:0] A5_BITS = 11'b10101001010;
`else
  localparam int NB = 10;
  localparam logic [NB-1:0] A5_BITS = 10'b1101001010;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_enb;
  logic       tx;
  logic       busy;
  logic [7:0] byte_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  int bad_pop = 0;
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] mem [0:63];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd_enb(fifo_rd_enb),
    .tx(tx),
    .busy(busy),
    .byte_cnt(byte_cnt)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port model: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_rd_enb) begin
      pop_cnt <= pop_cnt + 1;
      if (fifo_empty) bad_pop <= bad_pop + 1;
      else begin
        fifo_data <= mem[rd_ptr[5:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] frame_exp(input logic [7:0] b);
    logic [10:0] bits;
    logic [63:0] v;
    bits = {2'b11, b, 1'b0};
`ifdef FIFO_UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    v = '0;
    for (int i = 0; i < FL; i++) v[i] = bits[i / CPB];
    return v;
  endfunction

  // Waits for a start bit (bounded), then captures one sample per cycle.
  task automatic rx_frame(input string tag, input logic [7:0] b, input int drop_at,
                          output int gap, output logic [63:0] got);
    got = '0;
    gap = 0;
    @(negedge clk);
    while (tx !== 1'b0 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    chk({tag, "_start"}, 64'(tx), 64'(0));
    for (int i = 0; i < FL; i++) begin
      got[i] = tx;
      if (i == drop_at) enable = 1'b0;
      if (i != FL - 1) @(negedge clk);
    end
    chk({tag, "_bits"}, got, frame_exp(b));
  endtask

  initial begin
    int g;
    int p0;
    int viol;
    int t;
    logic [63:0] got;
    logic [NB-1:0] dec;

    // reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'(1));
    chk("rst_rd_enb", 64'(fifo_rd_enb), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_byte_cnt", 64'(byte_cnt), 64'(0));
    rst = 1'b0;

    // single byte 0xA5
    p0 = pop_cnt;
    push(8'hA5);
    enable = 1'b1;
    rx_frame("t1", 8'hA5, -1, g, got);
    for (int i = 0; i < NB; i++) dec[i] = got[i * CPB + 1];
    chk("t1_hand", 64'(dec), 64'(A5_BITS));
    @(negedge clk);
    chk("t1_byte_cnt", 64'(byte_cnt), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    chk("t1_pops", 64'(pop_cnt - p0), 64'(1));

    // three queued bytes back to back
    do_reset();
    push(8'h01); push(8'h80); push(8'hFF);
    p0 = pop_cnt;
    enable = 1'b1;
    rx_frame("t2a", 8'h01, -1, g, got);
    rx_frame("t2b", 8'h80, -1, g, got);
    chk("t2b_gap", 64'(g), 64'(2));
    rx_frame("t2c", 8'hFF, -1, g, got);
    chk("t2c_gap", 64'(g), 64'(2));
    @(negedge clk);
    chk("t2_byte_cnt", 64'(byte_cnt), 64'(3));
    chk("t2_pops", 64'(pop_cnt - p0), 64'(3));
    chk("t2_empty", 64'(fifo_empty), 64'(1));
    chk("t2_busy", 64'(busy), 64'(0));

    // empty FIFO, enabled: nothing happens
    do_reset();
    enable = 1'b1;
    p0 = pop_cnt;
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (fifo_rd_enb !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    chk("t3_idle_viol", 64'(viol), 64'(0));
    chk("t3_pops", 64'(pop_cnt - p0), 64'(0));

    // reset during data bit 3 of 0x3C, then 0x5A follows cleanly
    do_reset();
    push(8'h3C); push(8'h5A);
    p0 = pop_cnt;
    enable = 1'b1;
    t = 0;
    @(negedge clk);
    while (tx !== 1'b0 && t < 300) begin
      t++;
      @(negedge clk);
    end
    chk("t4_start", 64'(tx), 64'(0));
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    chk("t4_bit3", 64'(tx), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_tx", 64'(tx), 64'(1));
    chk("t4_rst_busy", 64'(busy), 64'(0));
    chk("t4_rst_byte_cnt", 64'(byte_cnt), 64'(0));
    rx_frame("t4b", 8'h5A, -1, g, got);
    @(negedge clk);
    chk("t4_byte_cnt", 64'(byte_cnt), 64'(1));
    chk("t4_pops", 64'(pop_cnt - p0), 64'(2));

    // enable gating
    do_reset();
    push(8'h11); push(8'h22);
    p0 = pop_cnt;
    repeat (50) @(negedge clk);
    chk("t5_dis_pops", 64'(pop_cnt - p0), 64'(0));
    chk("t5_dis_busy", 64'(busy), 64'(0));
    chk("t5_dis_tx", 64'(tx), 64'(1));
    enable = 1'b1;
    rx_frame("t5a", 8'h11, -1, g, got);
    rx_frame("t5b", 8'h22, -1, g, got);
    chk("t5b_gap", 64'(g), 64'(2));
    @(negedge clk);
    chk("t5_pops2", 64'(pop_cnt - p0), 64'(2));
    push(8'h33); push(8'h44);
    rx_frame("t5c", 8'h33, 8, g, got);
    repeat (30) @(negedge clk);
    chk("t5_drop_pops", 64'(pop_cnt - p0), 64'(3));
    chk("t5_drop_busy", 64'(busy), 64'(0));
    chk("t5_drop_byte_cnt", 64'(byte_cnt), 64'(3));
    enable = 1'b1;
    rx_frame("t5d", 8'h44, -1, g, got);
    @(negedge clk);
    chk("t5_byte_cnt", 64'(byte_cnt), 64'(4));
    chk("t5_empty", 64'(fifo_empty), 64'(1));

`ifdef FIFO_UART_TX_PARITY_EN
    // parity bit values and 44-cycle frame
    do_reset();
    push(8'h07); push(8'h03);
    enable = 1'b1;
    rx_frame("t6a", 8'h07, -1, g, got);
    chk("t6_par07", 64'(got[9 * CPB + 1]), 64'(1));
    rx_frame("t6b", 8'h03, -1, g, got);
    chk("t6_par03", 64'(got[9 * CPB + 1]), 64'(0));
    chk("t6_gap", 64'(g), 64'(2));
    @(negedge clk);
    chk("t6_byte_cnt", 64'(byte_cnt), 64'(2));
`endif

    chk("no_pop_when_empty", 64'(bad_pop), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
